// File: rtl/cv32e40p_pkg.sv
// Shared types and defaults for the fault-tolerant (TMR) multiplier health control.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    FT_TMR  = 2'b00,
    FT_DMR  = 2'b01,
    FT_FAIL = 2'b10
  } mult_ft_mode_e;

  localparam int unsigned FT_CNT_W_DEFAULT     = 8;
  localparam int unsigned FT_SCORE_INC_DEFAULT = 1;
  localparam int unsigned FT_SCORE_DEC_DEFAULT = 2;
  localparam int unsigned FT_THRESH_DEFAULT    = 100;

endpackage

// File: rtl/cv32e40p_ft_leaky_counter.sv
// Leaky-bucket error score for one multiplier replica: climbs on disagreement, drains on clean votes.
module cv32e40p_ft_leaky_counter #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned INC    = 1,
  parameter int unsigned DEC    = 2,
  parameter int unsigned THRESH = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_i,
  input  logic             err_i,
  input  logic             clr_i,
  input  logic             frz_i,
  output logic [CNT_W-1:0] score_o,
  output logic             over_o
);

  localparam logic [CNT_W:0] SCORE_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] score_q;
  logic [CNT_W:0]   score_sum;
  logic [CNT_W-1:0] score_inc;
  logic [CNT_W-1:0] score_dec;

  // Extra sum bit detects overflow so the score saturates instead of wrapping.
  always_comb begin
    score_sum = {1'b0, score_q} + (CNT_W+1)'(INC);
    score_inc = (score_sum > SCORE_MAX) ? SCORE_MAX[CNT_W-1:0] : score_sum[CNT_W-1:0];
    score_dec = (score_q < CNT_W'(DEC)) ? '0 : score_q - CNT_W'(DEC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score_q <= '0;
    end else if (clr_i) begin
      score_q <= '0;
    end else if (upd_i && !frz_i) begin
      score_q <= err_i ? score_inc : score_dec;
    end
  end

  assign score_o = score_q;
  assign over_o  = (score_q > CNT_W'(THRESH));

endmodule

// File: rtl/cv32e40p_mult_ft_health_ctrl.sv
// Health controller for the triplicated multiplier: scores replicas, retires the worst,
// and degrades the datapath mode TMR -> DMR -> FAIL.
module cv32e40p_mult_ft_health_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned CNT_W  = FT_CNT_W_DEFAULT,
  parameter int unsigned INC    = FT_SCORE_INC_DEFAULT,
  parameter int unsigned DEC    = FT_SCORE_DEC_DEFAULT,
  parameter int unsigned THRESH = FT_THRESH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vote_valid_i,
  input  logic [2:0]    err_replica_i,
  input  logic          dmr_mismatch_i,
  input  logic          clr_score_i,
  output logic [2:0]    replica_en_o,
  output logic [2:0]    retired_o,
  output logic [2:0]    perf_fault_o,
  output mult_ft_mode_e mode_o,
  output logic          uncorrectable_o
);

  mult_ft_mode_e mode_q, mode_d;
  logic [2:0]    retired_q, retired_d;
  logic [2:0]    perf_q, perf_d;
  logic [2:0]    en_q;
  logic [2:0]    over;
  logic [2:0]    cand;
  logic [2:0]    retire_sel;
  logic          unc;

  for (genvar i = 0; i < 3; i++) begin : g_score
    logic [CNT_W-1:0] score;
    cv32e40p_ft_leaky_counter #(
      .CNT_W (CNT_W),
      .INC   (INC),
      .DEC   (DEC),
      .THRESH(THRESH)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .upd_i  (vote_valid_i & ~retired_q[i]),
      .err_i  (err_replica_i[i]),
      .clr_i  (clr_score_i),
      .frz_i  (mode_q != FT_TMR),
      .score_o(score),
      .over_o (over[i])
    );
  end

  // Only the lowest-index over-threshold replica is retired; the rest stay in service.
  assign cand       = over & ~retired_q;
  assign retire_sel = cand & (~cand + 3'd1);

  always_comb begin
    mode_d    = mode_q;
    retired_d = retired_q;
    perf_d    = '0;
    unc       = 1'b0;
    case (mode_q)
      FT_TMR: begin
        unc = vote_valid_i & (&err_replica_i);
        if (|cand) begin
          retired_d = retired_q | retire_sel;
          perf_d    = retire_sel;
          mode_d    = FT_DMR;
        end
      end
      FT_DMR: begin
        unc = vote_valid_i & dmr_mismatch_i;
        if (unc) mode_d = FT_FAIL;
      end
      FT_FAIL: begin
        unc = vote_valid_i;
      end
      default: begin
        unc    = vote_valid_i;
        mode_d = FT_FAIL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= FT_TMR;
      retired_q <= '0;
      perf_q    <= '0;
      en_q      <= 3'b111;
    end else begin
      mode_q    <= mode_d;
      retired_q <= retired_d;
      perf_q    <= perf_d;
      en_q      <= ~retired_d;
    end
  end

  assign replica_en_o    = en_q;
  assign retired_o       = retired_q;
  assign perf_fault_o    = perf_q;
  assign mode_o          = mode_q;
  assign uncorrectable_o = unc;

endmodule

// File: tb/tb_cv32e40p_mult_ft_health_ctrl.sv
// Self-checking bench: a cycle model of the health rules plus directed literal checks.
module tb_cv32e40p_mult_ft_health_ctrl;

  logic       clk;
  logic       rst_n;
  logic       vote_valid;
  logic [2:0] err_replica;
  logic       dmr_mismatch;
  logic       clr_score;
  logic [2:0] replica_en;
  logic [2:0] retired;
  logic [2:0] perf_fault;
  logic [1:0] mode;
  logic       uncorrectable;

  int checks   = 0;
  int failures = 0;
  int last_unc = 0;

  // Model state, in plain integers.
  int m_score[3];
  int m_retired[3];
  int m_pf[3];
  int m_mode;
  bit model_valid = 0;

  cv32e40p_mult_ft_health_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vote_valid_i   (vote_valid),
    .err_replica_i  (err_replica),
    .dmr_mismatch_i (dmr_mismatch),
    .clr_score_i    (clr_score),
    .replica_en_o   (replica_en),
    .retired_o      (retired),
    .perf_fault_o   (perf_fault),
    .mode_o         (mode),
    .uncorrectable_o(uncorrectable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, sample the combinational flag mid-cycle, end just past the edge.
  task automatic applyStimulus(input bit v, input bit [2:0] e, input bit mm, input bit c);
    vote_valid   = v;
    err_replica  = e;
    dmr_mismatch = mm;
    clr_score    = c;
    #2;
    last_unc = int'(uncorrectable);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  // Behavioural model of the health rules.
  always @(posedge clk) begin : model
    int crossing;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_score[i] = 0; m_retired[i] = 0; m_pf[i] = 0;
      end
      m_mode = 0;
    end else begin
      crossing = -1;
      for (int i = 0; i < 3; i++) m_pf[i] = 0;
      if (m_mode == 0)
        for (int i = 0; i < 3; i++)
          if (crossing < 0 && m_retired[i] == 0 && m_score[i] > 100) crossing = i;
      if (clr_score) begin
        for (int i = 0; i < 3; i++) m_score[i] = 0;
      end else if (vote_valid && m_mode == 0) begin
        for (int i = 0; i < 3; i++)
          if (m_retired[i] == 0)
            m_score[i] = err_replica[i] ? ((m_score[i] + 1 > 255) ? 255 : m_score[i] + 1)
                                        : ((m_score[i] - 2 < 0) ? 0 : m_score[i] - 2);
      end
      if (crossing >= 0) begin
        m_retired[crossing] = 1;
        m_pf[crossing]      = 1;
        m_mode              = 1;
      end else if (m_mode == 1 && vote_valid && dmr_mismatch) begin
        m_mode = 2;
      end
    end
    model_valid = 1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int exp_ret, exp_pf, exp_en, exp_unc;
    if (model_valid) begin
      exp_ret = 0; exp_pf = 0;
      for (int i = 0; i < 3; i++) begin
        exp_ret += m_retired[i] << i;
        exp_pf  += m_pf[i] << i;
      end
      exp_en  = 7 - exp_ret;
      exp_unc = (rst_n && vote_valid && ((m_mode == 0 && err_replica == 3'b111) ||
                 (m_mode == 1 && dmr_mismatch) || m_mode == 2)) ? 1 : 0;
      checkOutput("cyc_retired", int'(retired), exp_ret);
      checkOutput("cyc_perf_fault", int'(perf_fault), exp_pf);
      checkOutput("cyc_replica_en", int'(replica_en), exp_en);
      checkOutput("cyc_mode", int'(mode), m_mode);
      if (rst_n) checkOutput("cyc_uncorrectable", int'(uncorrectable), exp_unc);
    end
  end

  initial begin
    rst_n        = 1'b0;
    vote_valid   = 1'b0;
    err_replica  = 3'b000;
    dmr_mismatch = 1'b0;
    clr_score    = 1'b0;
    @(posedge clk);
    #1;
    doReset(2);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
    checkOutput("rst_mode", int'(mode), 0);
    checkOutput("rst_en", int'(replica_en), 7);
    checkOutput("rst_retired", int'(retired), 0);
    checkOutput("rst_perf", int'(perf_fault), 0);

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    checkOutput("clean_mode", int'(mode), 0);
    checkOutput("clean_en", int'(replica_en), 7);
    checkOutput("clean_unc", last_unc, 0);

    for (int i = 0; i < 101; i++) begin
      applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
      if (i == 99) checkOutput("r0_at_100_votes", int'(retired), 0);
    end
    checkOutput("r0_at_101_votes", int'(retired), 0);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
    checkOutput("r0_retired", int'(retired), 1);
    checkOutput("r0_en", int'(replica_en), 6);
    checkOutput("r0_perf", int'(perf_fault), 1);
    checkOutput("r0_mode_dmr", int'(mode), 1);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
    checkOutput("r0_perf_once", int'(perf_fault), 0);

    applyStimulus(1'b1, 3'b000, 1'b1, 1'b0);
    checkOutput("dmr_mismatch_unc", last_unc, 1);
    checkOutput("dmr_to_fail", int'(mode), 2);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    checkOutput("fail_unc", last_unc, 1);
    checkOutput("fail_en", int'(replica_en), 6);
    checkOutput("fail_sticky", int'(mode), 2);

    doReset(1);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
    checkOutput("rst2_mode", int'(mode), 0);
    checkOutput("rst2_en", int'(replica_en), 7);

    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 3'b010, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    end
    checkOutput("alt_no_retire", int'(retired), 0);

    applyStimulus(1'b1, 3'b111, 1'b0, 1'b0);
    checkOutput("all_err_unc", last_unc, 1);
    checkOutput("all_err_mode", int'(mode), 0);

    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 3'b110, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b110, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 3'b110, 1'b0, 1'b0);
    checkOutput("clr_delays_retire", int'(retired), 0);
    applyStimulus(1'b1, 3'b110, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
    checkOutput("dual_retired", int'(retired), 2);
    checkOutput("dual_perf", int'(perf_fault), 2);
    checkOutput("dual_en", int'(replica_en), 5);
    checkOutput("dual_mode", int'(mode), 1);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
    checkOutput("dual_no_second", int'(retired), 2);
    checkOutput("dual_perf_once", int'(perf_fault), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
